// File: rtl/cpu_trace_buffer_pkg.sv
// Shared encodings and record layout for the CPU trace buffer.
package cpu_trace_buffer_pkg;

  typedef enum logic [1:0] {
    CPU_FETCH   = 2'd0,
    CPU_DECODE  = 2'd1,
    CPU_EXECUTE = 2'd2,
    CPU_MEMORY  = 2'd3
  } cpu_state_e;

  typedef enum logic [1:0] {
    TR_IDLE    = 2'd0,
    TR_ARMED   = 2'd1,
    TR_CAPTURE = 2'd2,
    TR_DONE    = 2'd3
  } trace_state_e;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;
  localparam int ALU_W   = 32;
  localparam int REC_W   = PC_W + INSTR_W + ALU_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instruction;
    logic [ALU_W-1:0]   alu_result;
    logic               change_pc;
  } trace_rec_t;

endpackage

// File: rtl/cpu_trace_buffer_fifo.sv
// Show-ahead synchronous FIFO with flush and drop-oldest support.
module trace_fifo #(
  parameter int DATA_W = 97,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     drop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic              do_pop;

  // drop advances the head so a push into a full FIFO replaces the oldest entry
  assign do_pop = pop | drop;
  assign valid  = (count != '0);
  assign level  = count;
  assign dout   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Trace capture for the multi-cycle core: event detect, trigger FSM, counters and record FIFO.
module cpu_trace_buffer
  import cpu_trace_buffer_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int MAX_CAPTURE = 0,
  parameter int SEQ_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             cpu_state,
  input  logic [15:0]            cpu_pc,
  input  logic [31:0]            cpu_instruction,
  input  logic [31:0]            cpu_alu_result,
  input  logic                   cpu_change_pc,
  input  logic                   arm,
  input  logic                   trig_en,
  input  logic [15:0]            trig_pc,
  input  logic                   stop_when_full,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [15:0]            rd_pc,
  output logic [31:0]            rd_instruction,
  output logic [31:0]            rd_alu_result,
  output logic                   rd_change_pc,
  output logic [SEQ_W-1:0]       rd_seq,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            overflow_count,
  output logic [1:0]             trace_state,
  output logic                   done
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  trace_state_e state_q, state_d;
  logic [1:0]   prev_state;
  logic [SEQ_W-1:0] seq_q;
  logic [31:0]  cap_cnt;
  logic         retire, record, full, pop, push, drop, loss, cap_hit;
  trace_rec_t   rec_in, head_rec;
  logic [REC_W+SEQ_W-1:0] fifo_dout;

  assign retire  = (cpu_state == CPU_EXECUTE) && (prev_state != CPU_EXECUTE);
  assign record  = !arm && retire &&
                   ((state_q == TR_CAPTURE) || ((state_q == TR_ARMED) && (cpu_pc == trig_pc)));
  assign full    = (level == LVL_W'(DEPTH));
  assign pop     = rd_valid && rd_ready;
  assign loss    = record && full && !pop;
  assign push    = record && !(loss && stop_when_full);
  assign drop    = loss && !stop_when_full;
  assign cap_hit = (MAX_CAPTURE != 0) && (cap_cnt + 32'd1 == 32'(MAX_CAPTURE));

  assign rec_in = '{pc: cpu_pc, instruction: cpu_instruction,
                    alu_result: cpu_alu_result, change_pc: cpu_change_pc};

  trace_fifo #(.DATA_W(REC_W + SEQ_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (arm),
    .push    (push),
    .pop     (pop),
    .drop    (drop),
    .din     ({rec_in, seq_q}),
    .dout    (fifo_dout),
    .valid   (rd_valid),
    .level   (level)
  );

  assign {head_rec, rd_seq} = fifo_dout;
  assign rd_pc          = head_rec.pc;
  assign rd_instruction = head_rec.instruction;
  assign rd_alu_result  = head_rec.alu_result;
  assign rd_change_pc   = head_rec.change_pc;
  assign trace_state    = state_q;
  assign done           = (state_q == TR_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= TR_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (arm)                      state_d = trig_en ? TR_ARMED : TR_CAPTURE;
    else if (record && cap_hit)   state_d = TR_DONE;
    else if (record)              state_d = TR_CAPTURE;
  end

  // seq advances for every accepted record, even ones lost to a full FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_state     <= 2'd0;
      seq_q          <= '0;
      cap_cnt        <= '0;
      overflow_count <= '0;
    end else begin
      prev_state <= cpu_state;
      if (arm) begin
        seq_q          <= '0;
        cap_cnt        <= '0;
        overflow_count <= '0;
      end else if (record) begin
        seq_q   <= seq_q + SEQ_W'(1);
        cap_cnt <= cap_cnt + 32'd1;
        if (loss && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: unlimited-capture instance plus a MAX_CAPTURE=2 instance.
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  cpu_state;
  logic [15:0] cpu_pc;
  logic [31:0] cpu_instruction;
  logic [31:0] cpu_alu_result;
  logic        cpu_change_pc;
  logic        arm, trig_en, stop_when_full, rd_ready;
  logic [15:0] trig_pc;

  logic        d_rd_valid, c_rd_valid;
  logic [15:0] d_rd_pc, c_rd_pc;
  logic [31:0] d_rd_instruction, c_rd_instruction;
  logic [31:0] d_rd_alu_result, c_rd_alu_result;
  logic        d_rd_change_pc, c_rd_change_pc;
  logic [15:0] d_rd_seq, c_rd_seq;
  logic [4:0]  d_level, c_level;
  logic [15:0] d_overflow_count, c_overflow_count;
  logic [1:0]  d_trace_state, c_trace_state;
  logic        d_done, c_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_trace_buffer #(.DEPTH(16), .MAX_CAPTURE(0), .SEQ_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .cpu_state(cpu_state), .cpu_pc(cpu_pc),
    .cpu_instruction(cpu_instruction), .cpu_alu_result(cpu_alu_result),
    .cpu_change_pc(cpu_change_pc), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .stop_when_full(stop_when_full), .rd_ready(rd_ready), .rd_valid(d_rd_valid),
    .rd_pc(d_rd_pc), .rd_instruction(d_rd_instruction), .rd_alu_result(d_rd_alu_result),
    .rd_change_pc(d_rd_change_pc), .rd_seq(d_rd_seq), .level(d_level),
    .overflow_count(d_overflow_count), .trace_state(d_trace_state), .done(d_done)
  );

  cpu_trace_buffer #(.DEPTH(16), .MAX_CAPTURE(2), .SEQ_W(16)) u_cap (
    .clk(clk), .reset_n(reset_n), .cpu_state(cpu_state), .cpu_pc(cpu_pc),
    .cpu_instruction(cpu_instruction), .cpu_alu_result(cpu_alu_result),
    .cpu_change_pc(cpu_change_pc), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .stop_when_full(stop_when_full), .rd_ready(rd_ready), .rd_valid(c_rd_valid),
    .rd_pc(c_rd_pc), .rd_instruction(c_rd_instruction), .rd_alu_result(c_rd_alu_result),
    .rd_change_pc(c_rd_change_pc), .rd_seq(c_rd_seq), .level(c_level),
    .overflow_count(c_overflow_count), .trace_state(c_trace_state), .done(c_done)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_arm(input logic te, input logic [15:0] tp);
    trig_en = te;
    trig_pc = tp;
    arm     = 1'b1;
    step();
    arm     = 1'b0;
  endtask

  // one FETCH cycle then one EXECUTE cycle; returns just after the retire edge
  task automatic retire(input logic [15:0] pc);
    cpu_state = 2'd0;
    step();
    cpu_state       = 2'd2;
    cpu_pc          = pc;
    cpu_instruction = {16'hA5A5, pc};
    cpu_alu_result  = {16'h0000, pc} + 32'h1000;
    cpu_change_pc   = pc[0];
    step();
    cpu_state = 2'd0;
  endtask

  task automatic test_reset();
    total++; if (d_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", d_rd_valid); end
    total++; if (d_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", d_level); end
    total++; if (d_overflow_count !== 16'd0) begin bad++; $display("FAIL reset_ovf got=%0d exp=0", d_overflow_count); end
    total++; if (d_trace_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", d_trace_state); end
    total++; if (d_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d exp=0", d_done); end
    total++; if (d_rd_pc !== 16'd0 || d_rd_seq !== 16'd0 || d_rd_instruction !== 32'd0)
      begin bad++; $display("FAIL reset_data got pc=%0h seq=%0h instr=%0h exp=0", d_rd_pc, d_rd_seq, d_rd_instruction); end
  endtask

  task automatic test_basic();
    rd_ready = 1'b1;
    stop_when_full = 1'b1;
    pulse_arm(1'b0, 16'h0);
    total++; if (d_trace_state !== 2'd2) begin bad++; $display("FAIL basic_state got=%0d exp=2", d_trace_state); end
    for (int i = 1; i <= 3; i++) begin
      retire(16'(i));
      total++; if (d_rd_valid !== 1'b1 || d_level !== 5'd1)
        begin bad++; $display("FAIL basic_valid%0d got v=%0d lvl=%0d exp v=1 lvl=1", i, d_rd_valid, d_level); end
      total++; if (d_rd_pc !== 16'(i)) begin bad++; $display("FAIL basic_pc%0d got=%0h exp=%0h", i, d_rd_pc, i); end
      total++; if (d_rd_seq !== 16'(i-1)) begin bad++; $display("FAIL basic_seq%0d got=%0d exp=%0d", i, d_rd_seq, i-1); end
    end
    total++; if (d_rd_instruction !== 32'hA5A50003 || d_rd_alu_result !== 32'h00001003 || d_rd_change_pc !== 1'b1)
      begin bad++; $display("FAIL basic_fields got ins=%0h alu=%0h br=%0d exp ins=a5a50003 alu=1003 br=1",
                             d_rd_instruction, d_rd_alu_result, d_rd_change_pc); end
    step();
    total++; if (d_level !== 5'd0 || d_rd_valid !== 1'b0)
      begin bad++; $display("FAIL basic_drain got lvl=%0d v=%0d exp lvl=0 v=0", d_level, d_rd_valid); end
    total++; if (d_overflow_count !== 16'd0) begin bad++; $display("FAIL basic_ovf got=%0d exp=0", d_overflow_count); end
  endtask

  task automatic test_trigger();
    rd_ready = 1'b0;
    pulse_arm(1'b1, 16'h0005);
    total++; if (d_trace_state !== 2'd1) begin bad++; $display("FAIL trig_armed got=%0d exp=1", d_trace_state); end
    retire(16'h3);
    retire(16'h4);
    total++; if (d_level !== 5'd0 || d_trace_state !== 2'd1)
      begin bad++; $display("FAIL trig_wait got lvl=%0d st=%0d exp lvl=0 st=1", d_level, d_trace_state); end
    retire(16'h5);
    total++; if (d_rd_valid !== 1'b1 || d_rd_pc !== 16'h5 || d_rd_seq !== 16'd0)
      begin bad++; $display("FAIL trig_first got v=%0d pc=%0h seq=%0d exp v=1 pc=5 seq=0", d_rd_valid, d_rd_pc, d_rd_seq); end
    total++; if (d_trace_state !== 2'd2) begin bad++; $display("FAIL trig_capture got=%0d exp=2", d_trace_state); end
    retire(16'h6);
    total++; if (d_level !== 5'd2 || d_rd_pc !== 16'h5)
      begin bad++; $display("FAIL trig_hold got lvl=%0d pc=%0h exp lvl=2 pc=5", d_level, d_rd_pc); end
    rd_ready = 1'b1;
    step();
    total++; if (d_rd_pc !== 16'h6 || d_rd_seq !== 16'd1)
      begin bad++; $display("FAIL trig_second got pc=%0h seq=%0d exp pc=6 seq=1", d_rd_pc, d_rd_seq); end
    step();
    total++; if (d_level !== 5'd0) begin bad++; $display("FAIL trig_drain got=%0d exp=0", d_level); end
    rd_ready = 1'b0;
  endtask

  task automatic test_fill(input logic swf);
    int exp_seq;
    rd_ready = 1'b0;
    stop_when_full = swf;
    pulse_arm(1'b0, 16'h0);
    for (int i = 0; i < 20; i++) retire(16'h100 + 16'(i));
    total++; if (d_level !== 5'd16) begin bad++; $display("FAIL fill%0d_level got=%0d exp=16", swf, d_level); end
    total++; if (d_overflow_count !== 16'd4) begin bad++; $display("FAIL fill%0d_ovf got=%0d exp=4", swf, d_overflow_count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_seq = swf ? i : i + 4;
      total++; if (d_rd_seq !== 16'(exp_seq) || d_rd_pc !== 16'h100 + 16'(exp_seq))
        begin bad++; $display("FAIL fill%0d_entry%0d got seq=%0d pc=%0h exp seq=%0d pc=%0h",
                               swf, i, d_rd_seq, d_rd_pc, exp_seq, 16'h100 + 16'(exp_seq)); end
      step();
    end
    total++; if (d_level !== 5'd0) begin bad++; $display("FAIL fill%0d_empty got=%0d exp=0", swf, d_level); end
    rd_ready = 1'b0;
  endtask

  task automatic test_max_capture();
    rd_ready = 1'b0;
    stop_when_full = 1'b1;
    pulse_arm(1'b0, 16'h0);
    for (int i = 0; i < 5; i++) retire(16'h20 + 16'(i));
    total++; if (c_level !== 5'd2) begin bad++; $display("FAIL cap_level got=%0d exp=2", c_level); end
    total++; if (c_done !== 1'b1 || c_trace_state !== 2'd3)
      begin bad++; $display("FAIL cap_done got done=%0d st=%0d exp done=1 st=3", c_done, c_trace_state); end
    total++; if (c_rd_pc !== 16'h20 || c_rd_seq !== 16'd0)
      begin bad++; $display("FAIL cap_head got pc=%0h seq=%0d exp pc=20 seq=0", c_rd_pc, c_rd_seq); end
    pulse_arm(1'b0, 16'h0);
    total++; if (c_done !== 1'b0 || c_level !== 5'd0 || c_overflow_count !== 16'd0 || c_trace_state !== 2'd2)
      begin bad++; $display("FAIL cap_rearm got done=%0d lvl=%0d ovf=%0d st=%0d exp 0 0 0 2",
                             c_done, c_level, c_overflow_count, c_trace_state); end
  endtask

  task automatic test_full_pop_reset();
    rd_ready = 1'b0;
    stop_when_full = 1'b1;
    pulse_arm(1'b0, 16'h0);
    for (int i = 0; i < 16; i++) retire(16'h300 + 16'(i));
    total++; if (d_level !== 5'd16 || d_overflow_count !== 16'd0)
      begin bad++; $display("FAIL fp_full got lvl=%0d ovf=%0d exp lvl=16 ovf=0", d_level, d_overflow_count); end
    cpu_state = 2'd0;
    step();
    cpu_state = 2'd2;
    cpu_pc    = 16'h200;
    rd_ready  = 1'b1;
    step();
    rd_ready  = 1'b0;
    cpu_state = 2'd0;
    total++; if (d_level !== 5'd16 || d_overflow_count !== 16'd0)
      begin bad++; $display("FAIL fp_pushpop got lvl=%0d ovf=%0d exp lvl=16 ovf=0", d_level, d_overflow_count); end
    total++; if (d_rd_seq !== 16'd1) begin bad++; $display("FAIL fp_head got=%0d exp=1", d_rd_seq); end
    reset_n = 1'b0;
    #1;
    total++; if (d_rd_valid !== 1'b0 || d_level !== 5'd0 || d_trace_state !== 2'd0)
      begin bad++; $display("FAIL midreset got v=%0d lvl=%0d st=%0d exp 0 0 0", d_rd_valid, d_level, d_trace_state); end
    total++; if (d_overflow_count !== 16'd0 || d_rd_seq !== 16'd0)
      begin bad++; $display("FAIL midreset_cnt got ovf=%0d seq=%0d exp 0 0", d_overflow_count, d_rd_seq); end
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; cpu_state = 2'd0; cpu_pc = '0; cpu_instruction = '0;
    cpu_alu_result = '0; cpu_change_pc = 1'b0; arm = 1'b0; trig_en = 1'b0;
    trig_pc = '0; stop_when_full = 1'b1; rd_ready = 1'b0;
    #2;
    test_reset();
    step();
    reset_n = 1'b1;
    step();
    test_basic();
    test_trigger();
    test_fill(1'b1);
    test_fill(1'b0);
    test_max_capture();
    test_full_pop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
